// File: rtl/jkff_pkg.sv
// Shared encodings for the JK flip-flop control input.
package jkff_pkg;

  localparam logic [1:0] JK_HOLD = 2'b00;
  localparam logic [1:0] JK_RST  = 2'b01;
  localparam logic [1:0] JK_SET  = 2'b10;
  localparam logic [1:0] JK_TGL  = 2'b11;

endpackage

// File: rtl/jkff.sv
// Single-bit JK flip-flop with complementary outputs and asynchronous reset.
// Positional port order (q, qb, jk, clk, rst) is relied on by existing instances.
module jkff
  import jkff_pkg::*;
#(
  parameter logic RESET_VAL = 1'b0
) (
  output logic       q,
  output logic       qb,
  input  logic [1:0] jk,
  input  logic       clk,
  input  logic       rst
);

  logic q_q, q_d;

  always_comb begin
    q_d = q_q;
    case (jk)
      JK_HOLD: q_d = q_q;
      JK_RST:  q_d = 1'b0;
      JK_SET:  q_d = 1'b1;
      JK_TGL:  q_d = ~q_q;
      default: q_d = q_q;
    endcase
  end

  // Reset is in the sensitivity list so it forces state without waiting for a clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) q_q <= RESET_VAL;
    else     q_q <= q_d;
  end

  assign q  = q_q;
  assign qb = ~q_q;

endmodule

// File: tb/tb_jkff.sv
// Bench for jkff: directed vector table, async-reset sequences, randomized run vs model.
module tb_jkff;
  import jkff_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] jk;
  logic       q, qb;

  int checks = 0;
  int errors = 0;

  jkff #(.RESET_VAL(1'b0)) dut (.q(q), .qb(qb), .jk(jk), .clk(clk), .rst(rst));

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [1:0] jk;
    logic       q;
  } vec_t;

  vec_t tbl[14];

  task automatic chk(input string nm, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%b exp=%b at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic chk_pair(input string nm, input logic exp);
    chk({nm, "_q"}, q, exp);
    chk({nm, "_qb"}, qb, ~exp);
  endtask

  initial begin
    logic m;
    logic j, k;

    tbl[0]  = '{1'b1, JK_SET,  1'b0};  // reset dominates set
    tbl[1]  = '{1'b0, JK_SET,  1'b1};
    tbl[2]  = '{1'b0, JK_SET,  1'b1};
    tbl[3]  = '{1'b0, JK_RST,  1'b0};
    tbl[4]  = '{1'b0, JK_RST,  1'b0};
    tbl[5]  = '{1'b0, JK_HOLD, 1'b0};
    tbl[6]  = '{1'b0, JK_HOLD, 1'b0};
    tbl[7]  = '{1'b0, JK_TGL,  1'b1};
    tbl[8]  = '{1'b0, JK_TGL,  1'b0};
    tbl[9]  = '{1'b0, JK_TGL,  1'b1};
    tbl[10] = '{1'b0, JK_TGL,  1'b0};
    tbl[11] = '{1'b0, JK_SET,  1'b1};
    tbl[12] = '{1'b0, JK_HOLD, 1'b1};
    tbl[13] = '{1'b0, JK_HOLD, 1'b1};

    rst = 1'b1;
    jk  = JK_SET;

    // Vectors applied on falling edges, checked 1 ns after the following rising edge.
    for (int i = 0; i < 14; i++) begin
      if (i > 0) @(negedge clk);
      rst = tbl[i].rst;
      jk  = tbl[i].jk;
      @(posedge clk);
      #1;
      chk_pair($sformatf("vec%0d", i), tbl[i].q);
    end

    // Async reset mid-toggle: q is 1 here; assert rst between edges.
    @(negedge clk);
    jk = JK_TGL;
    #2 rst = 1'b1;
    #1 chk_pair("async_rst_immediate", 1'b0);
    @(posedge clk);
    #1 chk_pair("edge_during_rst", 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1 chk_pair("tgl_after_release", 1'b1);
    @(posedge clk);
    #1 chk_pair("tgl_after_release2", 1'b0);

    // jk wiggles between edges must not matter; only the value at the edge counts.
    #1 jk = JK_SET;
    #2 jk = JK_TGL;
    #2 jk = JK_HOLD;
    @(posedge clk);
    #1 chk_pair("between_edge_wiggle", 1'b0);

    // Randomized run against the characteristic equation q+ = J&~q | ~K&q.
    m = 1'b0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 11) == 0);
      jk  = 2'($urandom);
      if (rst) begin
        m = 1'b0;
        #1 chk_pair("rnd_rst_level", m);
      end else if ($urandom_range(0, 9) == 0) begin
        // short reset pulse fully between edges
        #2 rst = 1'b1;
        #1 chk_pair("rnd_rst_pulse", 1'b0);
        m = 1'b0;
        #1 rst = 1'b0;
      end
      @(posedge clk);
      if (!rst) begin
        j = jk[1];
        k = jk[0];
        m = (j & ~m) | (~k & m);
      end
      #1 chk_pair($sformatf("rnd%0d", n), m);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
